// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - multi-stage valid/ready pipeline register with bubble collapse, flush and occupancy count
module elastic_pipe #(
  parameter int DATAW = 32,
  parameter int DEPTH = 2,
  localparam int CNTW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};
    assign in_ready  = out_ready & ~flush;
    assign out_valid = in_valid & ~flush;
    assign out_data  = in_data;
    assign count     = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] rdy;
    logic [DATAW-1:0] data_r [DEPTH];
    logic             tail_full;
    logic [CNTW-1:0]  cnt_nxt;
    logic [CNTW-1:0]  count_r;

    // rdy[i] unrolled: a stage may load unless it and every stage ahead are full and stalled
    always_comb begin
      rdy       = '0;
      tail_full = 1'b1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        tail_full = tail_full & valid_r[i];
        rdy[i]    = out_ready | ~tail_full;
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             src_valid;
      logic [DATAW-1:0] src_data;
      logic             v_q;
      logic [DATAW-1:0] d_q;

      if (i == 0) begin : g_src_in
        assign src_valid = in_valid;
        assign src_data  = in_data;
      end else begin : g_src_prev
        assign src_valid = valid_r[i-1];
        assign src_data  = data_r[i-1];
      end

      assign valid_nxt[i] = flush ? 1'b0 : (rdy[i] ? src_valid : v_q);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= valid_nxt[i];
          if (!flush && rdy[i] && src_valid) begin
            d_q <= src_data;
          end
        end
      end

      assign valid_r[i] = v_q;
      assign data_r[i]  = d_q;
    end

    always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_nxt = cnt_nxt + CNTW'(valid_nxt[i]);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count_r <= '0;
      end else begin
        count_r <= cnt_nxt;
      end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = valid_r[DEPTH-1] & ~flush;
    assign out_data  = data_r[DEPTH-1];
    assign count     = count_r;
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// tb/tb_elastic_pipe.sv - directed self-checking bench for elastic_pipe (DEPTH=3 and DEPTH=0)
module tb_elastic_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  logic       p_flush, p_in_valid, p_out_ready;
  logic [7:0] p_in_data;
  logic       p_in_ready, p_out_valid;
  logic [7:0] p_out_data;
  logic [0:0] p_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elastic_pipe #(.DATAW(8), .DEPTH(3)) u_pipe (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  elastic_pipe #(.DATAW(8), .DEPTH(0)) u_pass (
    .clk(clk), .rst(rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_data(p_in_data), .in_ready(p_in_ready),
    .out_valid(p_out_valid), .out_data(p_out_data), .out_ready(p_out_ready),
    .count(p_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] exp_d [7];
    logic       exp_v [7];
    logic [1:0] exp_c [7];
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 4);
      in_data  = 8'h11 * 8'(k + 1);
      tick();
      checks++; if (out_valid !== exp_v[k]) begin errors++; $display("FAIL stream_valid[%0d] got=%b want=%b", k, out_valid, exp_v[k]); end
      if (k >= 2) begin
        checks++; if (out_data !== exp_d[k]) begin errors++; $display("FAIL stream_data[%0d] got=%h want=%h", k, out_data, exp_d[k]); end
      end
      checks++; if (count !== exp_c[k]) begin errors++; $display("FAIL stream_count[%0d] got=%0d want=%0d", k, count, exp_c[k]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA1 + 8'(k);
      tick();
      checks++; if (count !== 2'(k + 1)) begin errors++; $display("FAIL bp_fill_count[%0d] got=%0d want=%0d", k, count, k + 1); end
    end
    in_data = 8'hA4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
    checks++; if (out_data !== 8'hA1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head got=%h/%b want=a1/1", out_data, out_valid); end
    tick();
    checks++; if (count !== 2'd3 || out_data !== 8'hA1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got=%0d/%h/%b want=3/a1/0", count, out_data, in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_push_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'hA2 || count !== 2'd3) begin errors++; $display("FAIL bp_pop_push got=%h/%0d want=a2/3", out_data, count); end
    tick();
    checks++; if (out_data !== 8'hA3 || count !== 2'd2) begin errors++; $display("FAIL bp_drain_a3 got=%h/%0d want=a3/2", out_data, count); end
    tick();
    checks++; if (out_data !== 8'hA4 || out_valid !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL bp_drain_a4 got=%h/%b/%0d want=a4/1/1", out_data, out_valid, count); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bp_empty got=%b/%0d want=0/0", out_valid, count); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 2'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL bubble_state got=%0d/%b want=2/1", count, in_ready); end
    checks++; if (out_data !== 8'h01 || out_valid !== 1'b1) begin errors++; $display("FAIL bubble_head got=%h/%b want=01/1", out_data, out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 8'h02 || out_valid !== 1'b1) begin errors++; $display("FAIL bubble_no_gap got=%h/%b want=02/1", out_data, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bubble_empty got=%b/%0d want=0/0", out_valid, count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'hB1 + 8'(k);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_mask got=%b/%b want=0/0", out_valid, in_ready); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_held_count got=%0d want=0", count); end
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_release got=%b/%b want=0/1", out_valid, in_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d] got=%b want=0", k, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'hC1 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL areset_full got=%0d want=3", count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 8'h00) begin errors++; $display("FAIL areset_clear got=%b/%0d/%h want=0/0/00", out_valid, count, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
    tick();
    rst = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hD1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_latency got=%b want=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hD1 || count !== 2'd1) begin errors++; $display("FAIL areset_restart got=%b/%h/%0d want=1/d1/1", out_valid, out_data, count); end
  endtask

  task automatic test_depth0();
    logic [3:0] pat;
    pat = 4'b1010;
    p_flush = 1'b0; p_in_valid = 1'b1; p_in_data = 8'h7E;
    for (int k = 0; k < 4; k++) begin
      p_out_ready = pat[k];
      #2;
      checks++; if (p_out_valid !== 1'b1 || p_out_data !== 8'h7E) begin errors++; $display("FAIL pass_out[%0d] got=%b/%h want=1/7e", k, p_out_valid, p_out_data); end
      checks++; if (p_in_ready !== pat[k] || p_count !== 1'b0) begin errors++; $display("FAIL pass_ready[%0d] got=%b/%0d want=%b/0", k, p_in_ready, p_count, pat[k]); end
    end
    p_out_ready = 1'b1; p_flush = 1'b1;
    #2;
    checks++; if (p_out_valid !== 1'b0 || p_in_ready !== 1'b0) begin errors++; $display("FAIL pass_flush got=%b/%b want=0/0", p_out_valid, p_in_ready); end
  endtask

  initial begin
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_data = 8'h00; p_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_depth0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised multi-stage pipeline register with per-stage valid bits and valid/ready flow control.
- Replaces free-running enable-based delay lines in the core wherever a stage can stall or be flushed, e.g. the IF→ID→EX path on branch redirect or a load-use stall.
- Adds backpressure, bubble collapse, synchronous flush and an occupancy count.

Parameters:
- DATAW, 32, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=0); 0 = combinational passthrough.
- CNTW, $clog2(DEPTH+1) (min 1), width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush, discards all stage contents.
- in_valid  input  1  upstream holds valid payload.
- in_data  input  DATAW  upstream payload.
- in_ready  output  1  pipe accepts in_data this cycle.
- out_valid  output  1  last stage holds valid payload.
- out_data  output  DATAW  last-stage payload.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  CNTW  number of valid stages.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low: asserting it (0) immediately clears valid_r[0..DEPTH-1] and data_r[0..DEPTH-1] to 0, independent of clk. Deassertion is synchronised externally.
- Reset values: out_valid=0, out_data=0, count=0, in_ready=1 (when flush=0).
- Stage state: valid_r[i] and data_r[i], i=0..DEPTH-1. Stage DEPTH-1 drives out_valid and out_data.
- Ready chain (combinational, bubble collapse):
  - rdy[DEPTH-1] = out_ready | ~valid_r[DEPTH-1].
  - rdy[i] = rdy[i+1] | ~valid_r[i] for i < DEPTH-1.
  - in_ready = rdy[0] & ~flush.
- Update on each edge with flush=0, for every stage where rdy[i]=1:
  - valid_r[i] <= src_valid.
  - data_r[i] <= src_data only if src_valid=1; otherwise data_r holds.
  - The source for stage 0 is in_valid/in_data; for stage i>0 it is stage i-1.
  - Stages with rdy[i]=0 hold valid and data.
- Handshakes:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Upstream must hold in_data stable while in_valid & ~in_ready. The pipe guarantees the same on its output side.
- Bubble collapse: a valid stage advances into an empty stage ahead of it even while out_ready=0. The pipe therefore fills to DEPTH entries before in_ready drops.
- Latency and throughput:
  - Empty pipe with out_ready=1: an item accepted at edge t is visible at out_valid after edge t+DEPTH-1, i.e. DEPTH cycles of latency.
  - Sustained throughput is 1 item/cycle.
- Flush:
  - The flush cycle masks out_valid=0 and in_ready=0 combinationally, so no transfer occurs in either direction.
  - At the next edge, all valid_r are cleared; data_r holds its old value.
  - Flush dominates a simultaneous in_valid, out_ready or stall; the in_valid item is dropped.
  - Flush held for several cycles keeps the pipe empty.
- count: registered, recomputed every edge as popcount of next-state valid_r. It equals the number of valid stages in the current cycle. Range is 0..DEPTH.
- Full: count==DEPTH & ~out_ready → in_ready=0. Full with out_ready=1 → in_ready=1, so simultaneous pop and push is allowed and count is unchanged.
- Empty: out_valid=0 and out_data holds its last value. Consumers must qualify out_data with out_valid.
- DEPTH=0:
  - in_ready = out_ready & ~flush.
  - out_valid = in_valid & ~flush.
  - out_data = in_data.
  - count = 0.
  - No state.
- Reset mid-operation clears all in-flight items asynchronously. The first post-reset edge behaves as the empty pipe.

Test Plan:
- Reset and stream (DATAW=8, DEPTH=3): rst low → out_valid=0, count=0, in_ready=1. Release, drive 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 → 0x11 at out_valid after 3 cycles, then one item/cycle in order, count=3 in steady state.
- Backpressure fill: out_ready=0, push 0xA1,0xA2,0xA3 → count 1,2,3. in_ready=0 after the third push; 0xA4 is held off. Raise out_ready → 0xA1..0xA3 emerge in order, 0xA4 accepted in the same cycle 0xA1 leaves.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02 with out_ready=0 → both occupy the last two stages with no gap, count=2, in_ready=1.
- Flush mid-stream: 3 valid items, assert flush with in_valid=1, in_data=0x55, out_ready=1 → out_valid=0 and in_ready=0 that cycle. Next cycle count=0; 0x55 never emerges.
- Async reset mid-operation: pipe full, pull rst low between clock edges → out_valid and count are 0 immediately, before the next edge. After release the stream restarts cleanly.
- DEPTH=0 passthrough: in_valid=1, in_data=0x7E, out_ready toggles → out_valid=1, out_data=0x7E same cycle, in_ready follows out_ready. flush=1 forces out_valid=0.
